// File: rtl/pic_bus_master.sv
// Bus master that drives 8259-style PIC write/read cycles with programmable
// setup/strobe/hold timing, sequencing ICW1..ICW4, single OCW writes and status reads.
module pic_bus_master #(
  parameter int T_SETUP  = 1,
  parameter int T_STROBE = 2,
  parameter int T_HOLD   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       init_req,
  input  logic [7:0] icw1,
  input  logic [7:0] icw2,
  input  logic [7:0] icw3,
  input  logic [7:0] icw4,
  input  logic       ocw_req,
  input  logic [1:0] ocw_sel,
  input  logic [7:0] ocw_data,
  input  logic       rd_req,
  input  logic       rd_a0,
  output logic       busy,
  output logic       done,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       cs_n,
  output logic       wr_n,
  output logic       rd_n,
  output logic       a0,
  output logic [7:0] d_out,
  output logic       d_oe,
  input  logic [7:0] d_in
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_GAP
  } state_t;

  localparam logic [3:0] LD_SETUP  = 4'(T_SETUP - 1);
  localparam logic [3:0] LD_STROBE = 4'(T_STROBE - 1);
  localparam logic [3:0] LD_HOLD   = 4'(T_HOLD - 1);

  // Returns {a0, data} for an OCW write; sel 00 never reaches here.
  function automatic logic [8:0] ocw_encode(input logic [1:0] sel, input logic [7:0] d);
    logic [8:0] r;
    unique case (sel)
      2'b01:   r = {1'b1, d};
      2'b10:   r = {1'b0, d & 8'hE7};
      2'b11:   r = {1'b0, (d & 8'hEF) | 8'h08};
      default: r = {1'b0, d};
    endcase
    return r;
  endfunction

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [2:0] word_idx, idx_nxt;
  logic [2:0] last_idx;
  logic       op_read;
  logic       done_nxt;
  logic       acc_init, acc_ocw, acc_rd, accept;
  logic       first_a0;
  logic [7:0] first_data;
  logic       read_nxt, active_nxt;
  logic [7:0] icw2_q, icw3_q, icw4_q;
  logic [7:0] later_word;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = word_idx;
    done_nxt  = 1'b0;
    acc_init  = 1'b0;
    acc_ocw   = 1'b0;
    acc_rd    = 1'b0;
    unique case (state)
      S_IDLE: begin
        // An illegal OCW select is treated as no request at all.
        acc_init = init_req;
        acc_ocw  = !init_req && ocw_req && (ocw_sel != 2'b00);
        acc_rd   = !init_req && !acc_ocw && rd_req;
        if (acc_init || acc_ocw || acc_rd) begin
          state_nxt = S_SETUP;
          cnt_nxt   = LD_SETUP;
          idx_nxt   = 3'd0;
        end
      end
      S_SETUP: begin
        if (cnt == 4'd0) begin
          state_nxt = S_STROBE;
          cnt_nxt   = LD_STROBE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      S_STROBE: begin
        if (cnt == 4'd0) begin
          state_nxt = S_HOLD;
          cnt_nxt   = LD_HOLD;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      S_HOLD: begin
        if (cnt == 4'd0) begin
          if (word_idx == last_idx) begin
            state_nxt = S_IDLE;
            done_nxt  = 1'b1;
            idx_nxt   = 3'd0;
          end else begin
            state_nxt = S_GAP;
            idx_nxt   = word_idx + 3'd1;
          end
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      S_GAP: begin
        state_nxt = S_SETUP;
        cnt_nxt   = LD_SETUP;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign accept = acc_init || acc_ocw || acc_rd;

  always_comb begin
    first_a0   = 1'b0;
    first_data = 8'h00;
    if (acc_init) begin
      first_data = icw1 | 8'h10;
    end else if (acc_ocw) begin
      {first_a0, first_data} = ocw_encode(ocw_sel, ocw_data);
    end else if (acc_rd) begin
      first_a0 = rd_a0;
    end
  end

  // Words after the first only occur in the init sequence (ICW2..ICW4, a0=1).
  always_comb begin
    unique case (word_idx)
      3'd1:    later_word = icw2_q;
      3'd2:    later_word = icw3_q;
      default: later_word = icw4_q;
    endcase
  end

  assign read_nxt   = accept ? acc_rd : op_read;
  assign active_nxt = (state_nxt == S_SETUP) || (state_nxt == S_STROBE) || (state_nxt == S_HOLD);

  // NOTE: state and registered outputs use non-blocking assignments so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      word_idx <= 3'd0;
      last_idx <= 3'd0;
      op_read  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= 8'h00;
      cs_n     <= 1'b1;
      wr_n     <= 1'b1;
      rd_n     <= 1'b1;
      a0       <= 1'b0;
      d_out    <= 8'h00;
      d_oe     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      word_idx <= idx_nxt;
      busy     <= (state_nxt != S_IDLE);
      done     <= done_nxt;
      rd_valid <= done_nxt && op_read;
      // Bus strobes are registered from the next state so they are glitch-free.
      cs_n     <= !active_nxt;
      wr_n     <= !((state_nxt == S_STROBE) && !read_nxt);
      rd_n     <= !((state_nxt == S_STROBE) && read_nxt);
      d_oe     <= active_nxt && !read_nxt;
      if (accept) begin
        op_read  <= acc_rd;
        last_idx <= acc_init ? (icw1[0] ? 3'd3 : 3'd2) : 3'd0;
        a0       <= first_a0;
        d_out    <= first_data;
      end else if (state == S_GAP) begin
        a0    <= 1'b1;
        d_out <= later_word;
      end
      // Capture on the last STROBE clock, while rd_n is still low.
      if ((state == S_STROBE) && (cnt == 4'd0) && op_read) begin
        rd_data <= d_in;
      end
    end
  end

  // NOTE: the ICW holding registers have no reset; they are always written on
  // init acceptance before any cycle can read them.
  always_ff @(posedge clk) begin
    if (acc_init) begin
      icw2_q <= icw2;
      icw3_q <= icw3;
      icw4_q <= icw4;
    end
  end

endmodule
